// File: rtl/mdu_seq_if.sv
// mdu_seq_if: start/operand/result handshake plus the borrowed-ALU port
// group for the multiply/divide sequencer. The master side is the CPU
// datapath (it launches operations and owns the shared ALU); the slave side
// is mdu_seq.
interface mdu_seq_if #(parameter int N = 32);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         alu_req;
    logic [N-1:0] alu_x;
    logic [N-1:0] alu_y;
    logic [3:0]   alu_op;
    logic [N-1:0] alu_z;

    modport master (
        output start, op, a, b, alu_z,
        input  busy, done, hi, lo, alu_req, alu_x, alu_y, alu_op
    );

    modport slave (
        input  start, op, a, b, alu_z,
        output busy, done, hi, lo, alu_req, alu_x, alu_y, alu_op
    );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULT/MULTU/DIV/DIVU sequencer. Borrows the shared ALU
// (ADD/SUB) for one pass per operand bit and leaves a 2N-bit result in hi/lo.
// Fixed latency: IDLE -> PREP -> ITER (N cycles) -> FIX -> DONE -> IDLE.
// Optional feature macro: MDU_SIGNED_EN (op[0]=1 selects signed operation;
// without it op[0] is ignored and FIX is an idle cycle).
module mdu_seq #(
    parameter int N = 32
) (
    input  logic     clk,
    input  logic     reset,
    mdu_seq_if.slave bus
);
    // ALU operation codes shared with the CPU ALU decoder
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam int         CW      = $clog2(N);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   hi_reg, hi_next;
    logic [N-1:0]   lo_reg, lo_next;
    logic [N-1:0]   opnd_reg, opnd_next;   // multiplicand (mult) or divisor (div)
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [N-1:0]   a_reg, b_reg;          // operands captured with start
    logic           is_div_reg;
    logic           signed_reg;

    logic           sgn_a, sgn_b;
    logic [N-1:0]   a_mag, b_mag;
    logic [N-1:0]   rem_shift;
    logic           take;
    logic           carry;
    logic           unused_op0;

    // Operand magnitudes; the sign bits only matter for signed operations
    assign sgn_a     = signed_reg & a_reg[N-1];
    assign sgn_b     = signed_reg & b_reg[N-1];
    assign a_mag     = sgn_a ? -a_reg : a_reg;
    assign b_mag     = sgn_b ? -b_reg : b_reg;
    // Restoring division: partial remainder shifted left by one dividend bit
    assign rem_shift = {hi_reg[N-2:0], lo_reg[N-1]};
    // hi[N-1] set means the shifted remainder exceeds N bits, so it always fits
    assign take      = hi_reg[N-1] | (rem_shift >= opnd_reg);
    // Carry out of the ALU add, recovered by an unsigned wrap compare
    assign carry     = (bus.alu_z < hi_reg);

    assign bus.hi    = hi_reg;
    assign bus.lo    = lo_reg;

`ifdef MDU_SIGNED_EN
    assign unused_op0 = 1'b0;
`else
    assign unused_op0 = bus.op[0];
`endif

    // Capture the launch operands once, when start is accepted in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            is_div_reg <= 1'b0;
            signed_reg <= 1'b0;
        end else if (state_reg == S_IDLE && bus.start) begin
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            is_div_reg <= bus.op[1];
`ifdef MDU_SIGNED_EN
            signed_reg <= bus.op[0];
`else
            signed_reg <= 1'b0;
`endif
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            hi_reg    <= '0;
            lo_reg    <= '0;
            opnd_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            opnd_reg  <= opnd_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ALU request: operands only during ITER, ADD otherwise
    always_comb begin
        bus.alu_req = 1'b0;
        bus.alu_x   = '0;
        bus.alu_y   = '0;
        bus.alu_op  = ALU_ADD;
        if (state_reg == S_ITER) begin
            bus.alu_req = 1'b1;
            if (is_div_reg) begin
                bus.alu_x  = rem_shift;
                bus.alu_y  = opnd_reg;
                bus.alu_op = ALU_SUB;
            end else begin
                bus.alu_x  = hi_reg;
                bus.alu_y  = lo_reg[0] ? opnd_reg : '0;
            end
        end
    end

    // Next-state, datapath update and status outputs
    always_comb begin
        state_next = state_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        opnd_next  = opnd_reg;
        cnt_next   = cnt_reg;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) state_next = S_PREP;
            end
            S_PREP: begin
                bus.busy  = 1'b1;
                hi_next   = '0;
                cnt_next  = CW'(N - 1);
                if (is_div_reg) begin
                    lo_next   = a_mag;
                    opnd_next = b_mag;
                end else begin
                    lo_next   = b_mag;
                    opnd_next = a_mag;
                end
                state_next = S_ITER;
            end
            S_ITER: begin
                bus.busy = 1'b1;
                if (is_div_reg) begin
                    hi_next = take ? bus.alu_z : rem_shift;
                    lo_next = {lo_reg[N-2:0], take};
                end else begin
                    hi_next = {carry, bus.alu_z[N-1:1]};
                    lo_next = {bus.alu_z[0], lo_reg[N-1:1]};
                end
                if (cnt_reg == '0) state_next = S_FIX;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            S_FIX: begin
                bus.busy = 1'b1;
                if (is_div_reg) begin
                    if (sgn_a ^ sgn_b) lo_next = -lo_reg;
                    if (sgn_a)         hi_next = -hi_reg;
                end else if (sgn_a ^ sgn_b) begin
                    {hi_next, lo_next} = -{hi_reg, lo_reg};
                end
                state_next = S_DONE;
            end
            S_DONE: begin
                bus.done   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed corner cases plus randomized operations for mdu_seq,
// checked against an arithmetic reference model. Provides a combinational
// ADD/SUB ALU for the sequencer to borrow.
module tb_mdu_seq;
    localparam int         N       = 32;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam int         LAT     = N + 3;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mdu_seq_if #(.N(N)) bus_if ();

    mdu_seq #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // Shared ALU stand-in: same-cycle combinational result
    assign bus_if.alu_z = (bus_if.alu_op == ALU_ADD) ? bus_if.alu_x + bus_if.alu_y :
                          (bus_if.alu_op == ALU_SUB) ? bus_if.alu_x - bus_if.alu_y :
                          32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {hi,lo} from plain arithmetic on the operation's definition
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic              sgn;
        longint            sp;
        longint unsigned   up;
        logic [31:0]       am, bm, q, r;
        sgn = 1'b0;
`ifdef MDU_SIGNED_EN
        sgn = op[0];
`endif
        if (!op[1]) begin
            if (sgn) begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            up = longint'(a) * longint'(b);
            return up;
        end
        am = (sgn && a[31]) ? -a : a;
        bm = (sgn && b[31]) ? -b : b;
        if (bm == 0) begin
            q = 32'hFFFF_FFFF;
            r = am;
        end else begin
            q = am / bm;
            r = am % bm;
        end
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31])           r = -r;
        return {r, q};
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Launch one operation, follow it to done, check timing and ALU usage.
    // With hold set, start stays high (with fresh junk operands) until done.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit hold, output logic [63:0] res);
        int lat, nreq, bad_op;
        bit got;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.a     = a;
        bus_if.b     = b;
        lat = 0; nreq = 0; bad_op = 0; got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (hold) begin
                bus_if.op = 2'($urandom_range(0, 3));
                bus_if.a  = $urandom;
                bus_if.b  = $urandom;
            end else begin
                bus_if.start = 1'b0;
            end
            if (lat == 1) chk_val({tag, "_busy1"}, 64'(bus_if.busy), 64'd1);
            if (bus_if.alu_req) begin
                nreq++;
                if (bus_if.alu_op !== (op[1] ? ALU_SUB : ALU_ADD)) bad_op++;
            end else if (bus_if.alu_op !== ALU_ADD) begin
                bad_op++;
            end
            if (bus_if.done) got = 1'b1;
        end
        chk_val({tag, "_done_seen"}, 64'(got), 64'd1);
        chk_val({tag, "_latency"}, 64'(lat), 64'(LAT));
        chk_val({tag, "_alu_req_cycles"}, 64'(nreq), 64'(N));
        chk_val({tag, "_alu_op"}, 64'(bad_op), 64'd0);
        chk_val({tag, "_busy_at_done"}, 64'(bus_if.busy), 64'd0);
        res = {bus_if.hi, bus_if.lo};
        $display("%s op=%0d a=%h b=%h hi=%h lo=%h lat=%0d", tag, op, a, b,
                 bus_if.hi, bus_if.lo, lat);
    endtask

    initial begin
        logic [63:0] res, held;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          dones;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus_if.start = 1'b0;
        bus_if.op = 2'b00;
        bus_if.a = '0;
        bus_if.b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_val("rst_busy", 64'(bus_if.busy), 64'd0);
        chk_val("rst_done", 64'(bus_if.done), 64'd0);
        chk_val("rst_hilo", {bus_if.hi, bus_if.lo}, 64'd0);
        chk_val("rst_alu_req", 64'(bus_if.alu_req), 64'd0);
        chk_val("rst_alu_xy", {bus_if.alu_x, bus_if.alu_y}, 64'd0);
        chk_val("rst_alu_op", 64'(bus_if.alu_op), 64'(ALU_ADD));

        // Reset in the middle of an iteration aborts cleanly
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op = 2'b00;
        bus_if.a = 32'hFFFF_FFFF;
        bus_if.b = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk_val("mid_busy", 64'(bus_if.busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_val("abort_busy", 64'(bus_if.busy), 64'd0);
        chk_val("abort_hilo", {bus_if.hi, bus_if.lo}, 64'd0);
        chk_val("abort_alu_req", 64'(bus_if.alu_req), 64'd0);
        chk_val("abort_alu_x", 64'(bus_if.alu_x), 64'd0);
        chk_val("abort_done", 64'(bus_if.done), 64'd0);

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res);
        chk_val("multu_max_res", res, 64'hFFFF_FFFE_0000_0001);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 1'b0, res);
        chk_val("divu_100_7_res", res, {32'd2, 32'd14});
        run_op("divu_by0", 2'b10, 32'd1234, 32'd0, 1'b0, res);
        chk_val("divu_by0_res", res, {32'd1234, 32'hFFFF_FFFF});
        run_op("mult_m3_5", 2'b01, -32'sd3, 32'd5, 1'b0, res);
`ifdef MDU_SIGNED_EN
        chk_val("mult_m3_5_res", res, 64'hFFFF_FFFF_FFFF_FFF1);
`else
        chk_val("mult_m3_5_res", res, 64'h0000_0004_FFFF_FFF1);
`endif
        run_op("div_m7_2", 2'b11, -32'sd7, 32'd2, 1'b0, res);
`ifdef MDU_SIGNED_EN
        chk_val("div_m7_2_res", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
`else
        chk_val("div_m7_2_res", res, {32'h1, 32'h7FFF_FFFC});
`endif
        run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, res);
`ifdef MDU_SIGNED_EN
        chk_val("div_min_m1_res", res, {32'h0, 32'h8000_0000});
`else
        chk_val("div_min_m1_res", res, {32'h8000_0000, 32'h0});
`endif

        // start held through busy and the done cycle: one result, first operands
        run_op("start_held", 2'b00, 32'd12345, 32'd678, 1'b1, res);
        chk_val("start_held_res", res, ref_result(2'b00, 32'd12345, 32'd678));
        held = res;
        dones = 1;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        if (bus_if.done) dones++;
        chk_val("held_no_relaunch", 64'(bus_if.busy), 64'd0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_if.done) dones++;
        end
        chk_val("held_single_done", 64'(dones), 64'd1);
        chk_val("held_idle_busy", 64'(bus_if.busy), 64'd0);
        chk_val("held_hilo_hold", {bus_if.hi, bus_if.lo}, held);

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick_val();
            rb  = pick_val();
            run_op($sformatf("rnd%0d", i), rop, ra, rb, 1'b0, res);
            chk_val($sformatf("rnd%0d_res", i), res, ref_result(rop, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
